// File: rtl/cnv_bin_bcd_w_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Imported by the converter top and its dabble cell.
package pkg_cnv;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } e_cnv_state;

  localparam logic [3:0] c_bcd_nine = 4'd9;

  // Largest value representable with n decimal digits (10^n - 1).
  function automatic logic [31:0] f_dec_max(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/cnv_bin_bcd_w_digit.sv
// Combinational double-dabble cell: a BCD nibble of 5 or more gets +3
// before the shift, so that the shift carries it into the next digit.
module cnv_bcd_dabble_digit
  import pkg_cnv::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add-3 correction ahead of the left shift.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/cnv_bin_bcd_w.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Results saturate to all 9s and are held until the next completed conversion.
module cnv_bin_bcd_w
  import pkg_cnv::*;
#(
  parameter int p_width     = 4,
  parameter int p_bin_width = 14
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [p_bin_width-1:0] i_bin,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic                   o_ovf,
  output logic [3:0]             o_bcd [p_width-1:0]
);

  localparam int c_cnt_w = $clog2(p_bin_width + 1);
  localparam int c_bcd_w = 4 * p_width;
  localparam int c_all_w = c_bcd_w + p_bin_width;
  localparam logic [p_bin_width-1:0] c_dec_max = p_bin_width'(f_dec_max(p_width));

  e_cnv_state           state_r;
  e_cnv_state           state_nxt_s;
  logic [c_cnt_w-1:0]   cnt_r;
  logic [c_bcd_w-1:0]   bcd_r;
  logic [p_bin_width-1:0] bin_r;
  logic                 ovf_q_r;
  logic [c_bcd_w-1:0]   adj_s;
  logic [c_all_w-1:0]   shift_all_s;
  logic [c_bcd_w-1:0]   bcd_shift_s;
  logic [p_bin_width-1:0] bin_shift_s;
  logic                 load_s;
  logic                 done_s;

  for (genvar g = 0; g < p_width; g++) begin : g_dig
    cnv_bcd_dabble_digit u_dig (
      .i_digit (bcd_r[4*g +: 4]),
      .o_digit (adj_s[4*g +: 4])
    );
  end

  // Corrected digits and binary shift left together; the top carry falls off.
  always_comb begin
    shift_all_s = {adj_s, bin_r} << 1;
    bcd_shift_s = shift_all_s[c_all_w-1:p_bin_width];
    bin_shift_s = shift_all_s[p_bin_width-1:0];
  end

  // Next-state decode: accept in IDLE, finish when the last shift is taken.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_nxt_s = SHIFT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == c_cnt_w'(1)) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register, bit counter and overflow latch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_r   <= '0;
      bcd_r   <= '0;
      bin_r   <= '0;
      ovf_q_r <= 1'b0;
    end else if (load_s) begin
      cnt_r   <= c_cnt_w'(p_bin_width);
      bcd_r   <= '0;
      bin_r   <= i_bin;
      ovf_q_r <= (i_bin > c_dec_max);
    end else if (state_r == SHIFT) begin
      cnt_r   <= cnt_r - c_cnt_w'(1);
      bcd_r   <= bcd_shift_s;
      bin_r   <= bin_shift_s;
    end
  end

  // Output registers; digits and overflow only move on completion.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      for (int i = 0; i < p_width; i++) begin
        o_bcd[i] <= 4'd0;
      end
    end else begin
      o_busy  <= (state_nxt_s == SHIFT);
      o_valid <= done_s;
      if (done_s) begin
        o_ovf <= ovf_q_r;
        for (int i = 0; i < p_width; i++) begin
          o_bcd[i] <= ovf_q_r ? c_bcd_nine : bcd_shift_s[4*i +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_cnv_bin_bcd_w.sv
// Scoreboard bench for cnv_bin_bcd_w: a 4-digit/14-bit instance and a
// 2-digit/8-bit instance, each with its own expectation queue and monitor.
module tb_cnv_bin_bcd_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [13:0] bin_a;
  logic [7:0]  bin_b;
  logic        busy_a, valid_a, ovf_a;
  logic        busy_b, valid_b, ovf_b;
  logic [3:0]  bcd_a [3:0];
  logic [3:0]  bcd_b [1:0];

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  cnv_bin_bcd_w #(.p_width(4), .p_bin_width(14)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_bin(bin_a),
    .o_busy(busy_a), .o_valid(valid_a), .o_ovf(ovf_a), .o_bcd(bcd_a)
  );

  cnv_bin_bcd_w #(.p_width(2), .p_bin_width(8)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_bin(bin_b),
    .o_busy(busy_b), .o_valid(valid_b), .o_ovf(ovf_b), .o_bcd(bcd_b)
  );

  function automatic logic [15:0] pack_a();
    return {bcd_a[3], bcd_a[2], bcd_a[1], bcd_a[0]};
  endfunction

  function automatic logic [15:0] pack_b();
    return {8'd0, bcd_b[1], bcd_b[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: every valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        check("a_expected_pending", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          check("a_bcd", {16'd0, pack_a()}, {16'd0, e.bcd});
          check("a_ovf", {31'd0, ovf_a}, {31'd0, e.ovf});
        end
      end
    end
  end

  // Monitor B.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_b) begin
        check("b_expected_pending", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          check("b_bcd", {16'd0, pack_b()}, {16'd0, e.bcd});
          check("b_ovf", {31'd0, ovf_b}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic go_a(input logic [13:0] b, input logic [15:0] eb, input logic eo, input bit push);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = b;
    if (push) q_a.push_back('{bcd: eb, ovf: eo});
    @(negedge clk);
    start_a = 1'b0;
    bin_a   = 14'($urandom);
  endtask

  task automatic go_b(input logic [7:0] b, input logic [15:0] eb, input logic eo);
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = b;
    q_b.push_back('{bcd: eb, ovf: eo});
    @(negedge clk);
    start_b = 1'b0;
    bin_b   = 8'($urandom);
  endtask

  // Entered in cycle 1 (after the accepting edge); returns in the valid cycle.
  task automatic wait_a(input string tag);
    int lat = 1;
    int busy_n = 0;
    logic [15:0] held;
    logic held_ok = 1'b1;
    held = pack_a();
    while (!valid_a && lat < 40) begin
      if (busy_a) busy_n++;
      if (pack_a() !== held) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd15);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd14);
    check({tag, "_busy_at_valid"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_held"}, {31'd0, held_ok}, 32'd1);
  endtask

  task automatic wait_b(input string tag);
    int lat = 1;
    int busy_n = 0;
    while (!valid_b && lat < 30) begin
      if (busy_b) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
    check({tag, "_bcd"}, {16'd0, pack_a()}, 32'd0);
  endtask

  // Directed stimulus.
  initial begin
    int n;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a   = 14'd0;
    bin_b   = 8'd0;
    // Start is asserted during reset: reset must win.
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 14'd1234;
    @(negedge clk);
    check_zero_a("rst_a");
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    check("rst_b_bcd", {16'd0, pack_b()}, 32'd0);
    start_a = 1'b0;
    rst_n   = 1'b1;

    go_a(14'd1234,  16'h1234, 1'b0, 1'b1); wait_a("c1234");
    go_a(14'd0,     16'h0000, 1'b0, 1'b1); wait_a("c0");
    go_a(14'd9999,  16'h9999, 1'b0, 1'b1); wait_a("c9999");
    go_a(14'd10000, 16'h9999, 1'b1, 1'b1); wait_a("c10000");
    go_a(14'd16383, 16'h9999, 1'b1, 1'b1); wait_a("c16383");
    go_a(14'd42,    16'h0042, 1'b0, 1'b1); wait_a("c42");

    // 777 pulsed mid-conversion is ignored; 777 held into the valid cycle is taken.
    go_a(14'd500, 16'h0500, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    bin_a   = 14'd777;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    bin_a   = 14'd777;
    n = 10;
    while (!valid_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovl_first_latency", 32'(n), 32'd15);
    q_a.push_back('{bcd: 16'h0777, ovf: 1'b0});
    @(negedge clk);
    start_a = 1'b0;
    n = 1;
    while (!valid_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", 32'(n), 32'd15);

    // Reset at cycle 7 of a conversion aborts it without a result.
    go_a(14'd1234, 16'h0000, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_a("abort");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    go_a(14'd1234, 16'h1234, 1'b0, 1'b1); wait_a("after_abort");

    go_b(8'd255, 16'h0099, 1'b1); wait_b("b255");
    go_b(8'd99,  16'h0099, 1'b0); wait_b("b99");
    go_b(8'd37,  16'h0037, 1'b0); wait_b("b37");

    repeat (5) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
